// File: rtl/ccta_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : ccta_pipe
// Brief  : Two-stage valid/ready select-and-add pipeline (add, alt-add,
//          subtract with borrow, running accumulate). Define CCTA_SAT_EN to
//          make the accumulate op saturate instead of wrap.
// Rev    : 1.0 - initial release
// ============================================================================
module ccta_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [1:0]       ctrl,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             acc_clr,
  output logic [WIDTH:0]   q,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ALT = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_ACC = 2'b11;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_c;
  logic [1:0]       s1_ctrl;
  logic [WIDTH:0]   acc;

  logic             s2_free;
  logic             advance;
  logic             accept;
  logic [WIDTH:0]   acc_base;
  logic [WIDTH+1:0] acc_sum;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH:0]   result;

  assign s2_free  = !out_valid || out_ready;
  assign advance  = s1_valid && s2_free;
  assign in_ready = rst_n && (!s1_valid || s2_free);
  assign accept   = in_valid && in_ready;

  always_comb begin
    // A clear on the same edge as an accumulate advance acts before the add.
    acc_base = acc_clr ? '0 : acc;
    acc_sum  = {1'b0, acc_base} + {2'b00, s1_a};
`ifdef CCTA_SAT_EN
    acc_next = acc_sum[WIDTH+1] ? '1 : acc_sum[WIDTH:0];
`else
    acc_next = acc_sum[WIDTH:0];
`endif
    result = '0;
    unique case (s1_ctrl)
      OP_ADD:  result = {1'b0, s1_a} + {1'b0, s1_b};
      OP_ALT:  result = {1'b0, s1_a} + {1'b0, s1_c};
      // The extra MSB of the widened difference is exactly the borrow.
      OP_SUB:  result = {1'b0, s1_a} - {1'b0, s1_b};
      OP_ACC:  result = acc_next;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
      s1_ctrl  <= 2'b00;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= A;
      s1_b     <= B;
      s1_c     <= C;
      s1_ctrl  <= ctrl;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= '0;
      out_valid <= 1'b0;
    end else if (advance) begin
      q         <= result;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (advance && (s1_ctrl == OP_ACC)) begin
      acc <= acc_next;
    end else if (acc_clr) begin
      acc <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ccta_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_ccta_pipe
// Brief  : Scoreboard bench for ccta_pipe (WIDTH=4) with directed and random
//          traffic; honours CCTA_SAT_EN for the accumulate expectations.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ccta_pipe;

  localparam int W    = 4;
  localparam int QMAX = (1 << (W + 1)) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] A, B, C;
  logic [1:0]   ctrl;
  logic         in_valid, in_ready, acc_clr, out_valid, out_ready;
  logic [W:0]   q;

  always #5 clk = ~clk;

  ccta_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .ctrl(ctrl),
    .in_valid(in_valid), .in_ready(in_ready), .acc_clr(acc_clr),
    .q(q), .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct {
    int a;
    int op;
    int exp;
    int cyc;
  } beat_t;

  beat_t      expq[$];
  int         lit_q[$];
  int         macc = 0;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  bit         chk_lat = 1'b0;
  bit         held = 1'b0;
  logic [W:0] held_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int acc_add(input int base, input int a);
    int s;
    s = base + a;
`ifdef CCTA_SAT_EN
    return (s > QMAX) ? QMAX : s;
`else
    return s % (QMAX + 1);
`endif
  endfunction

  // Reference: results are fixed in acceptance order; acc follows op-11 beats.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      cyc++;
      if (held) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_q", q, held_q);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_output", out_valid, 0);
        end else begin
          beat_t e;
          e = expq.pop_front();
          check("result", q, e.exp);
          if (lit_q.size() > 0) check("literal", q, lit_q.pop_front());
          if (chk_lat) check("latency", cyc - e.cyc, 2);
        end
      end
      held   = out_valid && !out_ready;
      held_q = q;
      if (acc_clr) begin
        // Sole in-flight op-11 beat accepted last edge advances on this edge: clear then add.
        if (expq.size() == 1 && expq[0].op == 3 && expq[0].cyc == cyc - 1) begin
          macc       = acc_add(0, expq[0].a);
          expq[0].exp = macc;
        end else begin
          macc = 0;
        end
      end
      if (in_valid && in_ready) begin
        beat_t n;
        n.a   = int'(A);
        n.op  = int'(ctrl);
        n.cyc = cyc;
        case (ctrl)
          2'd0: n.exp = int'(A) + int'(B);
          2'd1: n.exp = int'(A) + int'(C);
          2'd2: n.exp = (int'(A) >= int'(B)) ? int'(A) - int'(B) : int'(A) - int'(B) + 32;
          default: begin
            macc  = acc_add(macc, int'(A));
            n.exp = macc;
          end
        endcase
        expq.push_back(n);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input int a, input int b, input int c, input int op);
    bit got;
    int n;
    in_valid = 1'b1;
    A = W'(a); B = W'(b); C = W'(c); ctrl = 2'(op);
    got = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!got && n < 50);
    if (!got) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (expq.size() > 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", expq.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; A = '0; B = '0; C = '0; ctrl = 2'b00;
    in_valid = 1'b0; out_ready = 1'b0; acc_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_q", q, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Add / alt-add / subtract, back to back.
    chk_lat = 1'b1;
    lit_q = '{8, 15, 15, 4, 31};
    send(3, 5, 0, 0);
    send(10, 0, 5, 1);
    send(14, 1, 0, 0);
    send(6, 2, 0, 2);
    send(1, 2, 0, 2);
    drain();

    // Streaming: 10 beats, one per cycle.
    for (int i = 0; i < 10; i++)
      send($urandom_range(15), $urandom_range(15), $urandom_range(15), $urandom_range(2));
    drain();
    chk_lat = 1'b0;

    // Accumulate from a cleared accumulator.
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
`ifdef CCTA_SAT_EN
    lit_q = '{7, 14, 21, 28, 31};
`else
    lit_q = '{7, 14, 21, 28, 3};
`endif
    for (int i = 0; i < 5; i++) send(7, 0, 0, 3);
    drain();

    // Clear coincident with an accumulate advance, then one more add.
    lit_q = '{5, 7};
    send(5, 0, 0, 3);
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    drain();
    send(2, 0, 0, 3);
    drain();

    // Backpressure: 3 beats offered into a stalled output.
    out_ready = 1'b0;
    lit_q = '{3, 8, 6};
    fork
      begin
        send(1, 2, 0, 0);
        send(4, 4, 0, 0);
        send(9, 3, 0, 2);
      end
      begin
        repeat (4) @(posedge clk);
        #2;
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_held_beats", expq.size(), 2);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with beats in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; A = 4'd2; B = 4'd3; ctrl = 2'd0;
    @(posedge clk);
    #1;
    A = 4'd5; C = 4'd5; ctrl = 2'd1;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    in_valid = 1'b0;
    expq.delete();
    lit_q.delete();
    macc = 0;
    #1;
    check("midreset_q", q, 0);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_reset_no_output", out_valid, 0);

    // Randomised traffic with random backpressure and safe clears.
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(3) != 0);
      in_valid  = $urandom_range(1);
      A = W'($urandom_range(15));
      B = W'($urandom_range(15));
      C = W'($urandom_range(15));
      ctrl = 2'($urandom_range(3));
      acc_clr = (expq.size() == 0) && ($urandom_range(5) == 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    acc_clr = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
